// File: rtl/uart_core_cfg.sv
// Configurable full-duplex UART: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits,
// oversampled receiver with false-start rejection and parity/framing error flags.
module uart_core_cfg #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int BIT_CLKS = OVERSAMPLE * DIV;
    localparam int TMR_W    = $clog2(BIT_CLKS);
    localparam int DIV_W    = $clog2(DIV);
    localparam int SMP_W    = $clog2(OVERSAMPLE);
    localparam int CNT_W    = $clog2(DATA_BITS);
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(BIT_CLKS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] HALF_LAST = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] FULL_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] DBIT_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_cfg
        $error("uart_core_cfg: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t               tx_state_q, tx_state_d;
    logic [TMR_W-1:0]     tx_tmr_q, tx_tmr_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end, tx_accept;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_done    = 1'b0;
        tx_accept  = 1'b0;
        tx_bit_end = (tx_tmr_q == BIT_LAST);
        tx_tmr_d   = tx_bit_end ? '0 : tx_tmr_q + 1'b1;
        case (tx_state_q)
            S_IDLE: begin
                tx_tmr_d  = '0;
                tx_accept = tx_valid;
            end
            S_START: if (tx_bit_end) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = '0;
            end
            S_DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_cnt_q == DBIT_LAST) begin
                    tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    tx_stop_d  = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_PARITY: if (tx_bit_end) begin
                tx_state_d = S_STOP;
                tx_stop_d  = 1'b0;
            end
            S_STOP: if (tx_bit_end) begin
                if (tx_stop_q == STOP_LAST) begin
                    // accepting here lets a held tx_valid start the next frame with no gap
                    tx_done    = 1'b1;
                    tx_state_d = S_IDLE;
                    tx_accept  = tx_valid;
                end else begin
                    tx_stop_d = 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_accept) begin
            tx_state_d = S_START;
            tx_tmr_d   = '0;
            tx_shift_d = tx_data;
            tx_par_d   = (^tx_data) ^ PAR_ODD;
        end
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_tmr_q   <= '0;
            tx_cnt_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (tx_state_q == S_IDLE) | tx_done;

    // ---------------- receiver ----------------
    logic                 rx_meta_q, rx_sync_q;
    state_t               rx_state_q, rx_state_d;
    logic [DIV_W-1:0]     rx_div_q, rx_div_d;
    logic [SMP_W-1:0]     rx_smp_q, rx_smp_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_pchk_q, rx_pchk_d;
    logic                 rx_armed_q, rx_armed_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_tick, rx_sample;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_pchk_d  = rx_pchk_q;
        rx_armed_d = rx_armed_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_tick    = (rx_div_q == DIV_LAST);
        rx_sample  = rx_tick &&
                     (rx_smp_q == ((rx_state_q == S_START) ? HALF_LAST : FULL_LAST));
        rx_div_d   = rx_tick ? '0 : rx_div_q + 1'b1;
        rx_smp_d   = rx_sample ? '0 : rx_smp_q + SMP_W'(rx_tick);
        case (rx_state_q)
            S_IDLE: begin
                rx_div_d = '0;
                rx_smp_d = '0;
                // after a break the line must go high before another start is accepted
                if (rx_sync_q)       rx_armed_d = 1'b1;
                else if (rx_armed_q) rx_state_d = S_START;
            end
            S_START: if (rx_sample) begin
                if (rx_sync_q) begin
                    rx_state_d = S_IDLE;
                end else begin
                    rx_state_d = S_DATA;
                    rx_cnt_d   = '0;
                    rx_pchk_d  = 1'b0;
                end
            end
            S_DATA: if (rx_sample) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_cnt_q == DBIT_LAST) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                else                       rx_cnt_d   = rx_cnt_q + 1'b1;
            end
            S_PARITY: if (rx_sample) begin
                rx_pchk_d  = rx_sync_q ^ (^rx_shift_q) ^ PAR_ODD;
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_sample) begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
                rx_perr_d  = (PARITY != 0) && rx_pchk_q;
                rx_ferr_d  = ~rx_sync_q;
                rx_armed_d = rx_sync_q;
                rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_div_q   <= '0;
            rx_smp_q   <= '0;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_pchk_q  <= 1'b0;
            rx_armed_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_smp_q   <= rx_smp_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_pchk_q  <= rx_pchk_d;
            rx_armed_q <= rx_armed_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed + randomized bench for uart_core_cfg: 8N1 (tx timing, glitch, break, reset),
// 8E1 loopback and 8O1 parity checking, against a frame-list reference model.
module tb_uart_core_cfg;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int BIT      = 160;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rx_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 8N1 instance, rx driven by the bench
    logic       n_rx = 1'b1, n_tx_valid = 1'b0;
    logic [7:0] n_tx_data = '0;
    logic       n_tx_ready, n_tx, n_tx_done, n_rx_valid, n_perr, n_ferr;
    logic [7:0] n_rx_data;
    // 8E1 instance in loopback
    logic       e_tx_valid = 1'b0;
    logic [7:0] e_tx_data = '0;
    logic       e_tx_ready, e_tx, e_tx_done, e_rx_valid, e_perr, e_ferr;
    logic [7:0] e_rx_data;
    // 8O1 instance, rx driven by the bench
    logic       o_rx = 1'b1, o_tx_valid = 1'b0;
    logic [7:0] o_tx_data = '0;
    logic       o_tx_ready, o_tx, o_tx_done, o_rx_valid, o_perr, o_ferr;
    logic [7:0] o_rx_data;

    uart_core_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .OVERSAMPLE(OS)) u_n (
        .clk(clk), .rst(rst), .rx(n_rx), .tx_data(n_tx_data), .tx_valid(n_tx_valid),
        .tx_ready(n_tx_ready), .tx(n_tx), .tx_done(n_tx_done), .rx_data(n_rx_data),
        .rx_valid(n_rx_valid), .rx_parity_err(n_perr), .rx_frame_err(n_ferr));

    uart_core_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .OVERSAMPLE(OS)) u_e (
        .clk(clk), .rst(rst), .rx(e_tx), .tx_data(e_tx_data), .tx_valid(e_tx_valid),
        .tx_ready(e_tx_ready), .tx(e_tx), .tx_done(e_tx_done), .rx_data(e_rx_data),
        .rx_valid(e_rx_valid), .rx_parity_err(e_perr), .rx_frame_err(e_ferr));

    uart_core_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .OVERSAMPLE(OS)) u_o (
        .clk(clk), .rst(rst), .rx(o_rx), .tx_data(o_tx_data), .tx_valid(o_tx_valid),
        .tx_ready(o_tx_ready), .tx(o_tx), .tx_done(o_tx_done), .rx_data(o_rx_data),
        .rx_valid(o_rx_valid), .rx_parity_err(o_perr), .rx_frame_err(o_ferr));

    rx_t n_q[$], e_q[$], o_q[$];
    always @(negedge clk) begin
        if (n_rx_valid === 1'b1) n_q.push_back({n_rx_data, n_perr, n_ferr});
        if (e_rx_valid === 1'b1) e_q.push_back({e_rx_data, e_perr, e_ferr});
        if (o_rx_valid === 1'b1) o_q.push_back({o_rx_data, o_perr, o_ferr});
    end

    bit fbits[$];
    bit rbits[$];

    // Frame as a list of line levels, one entry per bit period.
    function automatic void make_frame(input logic [7:0] d, input int par);
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 0; i < 8; i++) fbits.push_back(d[i]);
        if (par == 1) fbits.push_back(($countones(d) % 2) == 0);
        if (par == 2) fbits.push_back(($countones(d) % 2) == 1);
        fbits.push_back(1'b1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input int which);
        for (int i = 0; i < fbits.size(); i++) begin
            if (which == 0) n_rx = fbits[i];
            else            o_rx = fbits[i];
            repeat (BIT) @(negedge clk);
        end
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_q(input int which, input int want, input string tag);
        int k = 0;
        while (((which == 0) ? n_q.size() : o_q.size()) < want && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_count"}, (which == 0) ? n_q.size() : o_q.size(), want);
    endtask

    task automatic check_rx(input rx_t r, input logic [7:0] d, input logic pe, input logic fe,
                            input string tag);
        check({tag, "_data"}, r.d, d);
        check({tag, "_perr"}, r.pe, pe);
        check({tag, "_ferr"}, r.fe, fe);
    endtask

    // Transmit one 8N1 word and check every clock of the frame against the model.
    task automatic run_tx_n(input logic [7:0] d, input string tag);
        int cnt, done_at, done_n, bad_bit, bad_rdy;
        make_frame(d, 0);
        @(negedge clk);
        n_tx_data  = d;
        n_tx_valid = 1'b1;
        check({tag, "_ready_idle"}, n_tx_ready, 1);
        @(negedge clk);
        n_tx_valid = 1'b0;
        cnt = 1; done_at = 0; done_n = 0; bad_bit = 0; bad_rdy = 0;
        while (cnt <= 1700) begin
            if (cnt <= 10 * BIT && n_tx !== fbits[(cnt - 1) / BIT]) bad_bit++;
            if (cnt < 10 * BIT && n_tx_ready !== 1'b0) bad_rdy++;
            if (n_tx_done === 1'b1) begin
                done_n++;
                if (done_at == 0) done_at = cnt;
            end
            if (cnt == 10 * BIT + 1) begin
                check({tag, "_tx_after"}, n_tx, 1);
                check({tag, "_ready_after"}, n_tx_ready, 1);
            end
            @(negedge clk);
            cnt++;
        end
        check({tag, "_bit_errs"}, bad_bit, 0);
        check({tag, "_busy_ready"}, bad_rdy, 0);
        check({tag, "_done_at"}, done_at, 10 * BIT);
        check({tag, "_done_pulses"}, done_n, 1);
    endtask

    initial begin
        logic [7:0] words[10];
        longint     acc[10];
        logic [7:0] w, wtx, wrx;
        int         base, k;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", n_tx, 1);
        check("rst_tx_ready", n_tx_ready, 1);
        check("rst_tx_done", n_tx_done, 0);
        check("rst_rx_data", n_rx_data, 0);
        check("rst_rx_valid", n_rx_valid, 0);
        check("rst_perr", n_perr, 0);
        check("rst_ferr", n_ferr, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 8N1 transmit timing
        run_tx_n(8'hA5, "t1");

        // 2: even-parity loopback, tx_valid held high
        for (int i = 0; i < 10; i++) words[i] = 8'($urandom);
        e_tx_data  = words[0];
        e_tx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            k = 0;
            while (e_tx_ready !== 1'b1 && k < 3000) begin
                @(negedge clk);
                k++;
            end
            check("t2_accept_timeout", k < 3000, 1);
            @(posedge clk);
            acc[i] = $time;
            if (i > 0) check("t2_frame_len", 32'(acc[i] - acc[i-1]), 11 * BIT * 10);
            @(negedge clk);
            if (i < 9) e_tx_data = words[i + 1];
            else       e_tx_valid = 1'b0;
        end
        k = 0;
        while (e_q.size() < 10 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("t2_count", e_q.size(), 10);
        for (int i = 0; i < 10 && i < e_q.size(); i++) check_rx(e_q[i], words[i], 0, 0, "t2");

        // 3: odd parity, wrong then right parity bit
        make_frame(8'h0F, 1);
        fbits[9] = ~fbits[9];
        send_frame(1);
        wait_q(1, 1, "t3_bad");
        if (o_q.size() >= 1) check_rx(o_q[0], 8'h0F, 1, 0, "t3_bad");
        make_frame(8'h0F, 1);
        send_frame(1);
        wait_q(1, 2, "t3_good");
        if (o_q.size() >= 2) check_rx(o_q[1], 8'h0F, 0, 0, "t3_good");

        // 4: 60-clock glitch is rejected, then a real frame
        base = n_q.size();
        n_rx = 1'b0;
        repeat (60) @(negedge clk);
        n_rx = 1'b1;
        repeat (400) @(negedge clk);
        check("t4_no_valid", n_q.size(), base);
        make_frame(8'h3C, 0);
        send_frame(0);
        wait_q(0, base + 1, "t4");
        if (n_q.size() > base) check_rx(n_q[base], 8'h3C, 0, 0, "t4");

        // 5: break of 30 bit times gives exactly one frame-error word
        base = n_q.size();
        n_rx = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        n_rx = 1'b1;
        check("t5_break_count", n_q.size(), base + 1);
        if (n_q.size() > base) check_rx(n_q[base], 8'h00, 0, 1, "t5_break");
        repeat (2 * BIT) @(negedge clk);
        make_frame(8'h81, 0);
        send_frame(0);
        wait_q(0, base + 2, "t5_after");
        if (n_q.size() > base + 1) check_rx(n_q[base + 1], 8'h81, 0, 0, "t5_after");

        // 6: reset with tx in data bit 3 and rx mid-data
        wtx  = 8'($urandom) & 8'hF7;  // data bit 3 low, so tx must visibly jump high
        wrx  = 8'($urandom);
        make_frame(wrx, 0);
        rbits = fbits;
        base  = n_q.size();
        @(negedge clk);
        n_tx_data  = wtx;
        n_tx_valid = 1'b1;
        @(negedge clk);
        n_tx_valid = 1'b0;
        for (int c = 0; c < 4 * BIT + 80; c++) begin
            n_rx = rbits[c / BIT];
            @(negedge clk);
        end
        check("t6_tx_low_before", n_tx, 0);
        #2 rst = 1'b0;
        n_rx = 1'b1;
        #1;
        check("t6_tx_async", n_tx, 1);
        check("t6_ready_async", n_tx_ready, 1);
        check("t6_rx_valid", n_rx_valid, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2000) @(negedge clk);
        check("t6_no_partial", n_q.size(), base);
        w = 8'($urandom);
        run_tx_n(w, "t6tx");
        w = 8'($urandom);
        make_frame(w, 0);
        send_frame(0);
        wait_q(0, base + 1, "t6rx");
        if (n_q.size() > base) check_rx(n_q[base], w, 0, 0, "t6rx");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
